mdu_seq: RTL and testbench
==========================

# mdu_seq

Multi-cycle sequencer for the RV64M multiply/divide operations, replacing the single-cycle `*`, `/` and `%` paths in the ALU. It sits beside the ALU in the execute stage. It accepts one operation through a valid/ready handshake, iterates a shared shift-add / restoring-divide datapath, applies sign correction, and holds the result until the pipeline takes it. While it is busy, execute stalls; the `flush` input lets a redirect abort an operation in flight.

## Interface
Parameters:
- `XLEN`, 64: operand and result width.

Ports:
- `clk` (input, 1): clock.
- `rst` (input, 1): reset, asynchronous and active-high.
- `in_valid` (input, 1): request present.
- `in_ready` (output, 1): high only in IDLE.
- `in_op` (input, `MduOpWidth` = 4): operation select, encodings in the package.
- `in_a` (input, XLEN): rs1 value.
- `in_b` (input, XLEN): rs2 value.
- `flush` (input, 1): abort the operation in flight; no result is produced.
- `out_valid` (output, 1): result available; high only in DONE.
- `out_ready` (input, 1): consumer takes the result.
- `out_result` (output, XLEN): final result, already sign-extended for W ops.

## Operation
- Ops: MUL, MULH, MULHSU, MULHU, MULW, DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW.
- States: IDLE, CALC, FIX, DONE.
  - IDLE goes to CALC on `in_valid & in_ready`. It goes straight to DONE for the special cases below.
  - CALC goes to FIX when the iteration counter hits N-1.
  - FIX goes to DONE.
  - DONE goes to IDLE on `out_ready`.
  - `flush` in any state forces IDLE at the next edge and overrides every other transition.
- Operand capture at accept:
  - W ops take bits [31:0]. Signed W ops sign-extend them; unsigned W ops zero-extend them.
  - Signed operands are converted to magnitude, and sign flags are latched.
  - MULHSU treats only `a` as signed.
- Iterations: N = 64 for full-width ops, 32 for W ops.
  - Multiply: radix-2 shift-add into a 2·XLEN accumulator, one bit per cycle.
  - Divide: restoring, one quotient bit per cycle; the remainder register is XLEN+1 bits.
- FIX: conditional two's-complement negate.
  - Product is negated if sign(a) XOR sign(b).
  - Quotient is negated if sign(a) XOR sign(b).
  - Remainder is negated if sign(a), so the remainder takes the dividend's sign.
- Result select:
  - MUL returns product[63:0].
  - MULH, MULHSU and MULHU return product[127:64].
  - MULW returns sext(product[31:0]).
  - W div/rem ops return sext of bits [31:0].
- Special cases resolve in IDLE with no iteration, going to DONE one cycle after accept:
  - Divide by zero (b, or b[31:0] for W ops, equal to 0): quotient is all ones (sext to −1 for W); remainder is a (sext(a[31:0]) for W).
  - Signed overflow (a = most-negative, b = −1, at the op's width): quotient is a; remainder is 0.
- `out_result` is registered and stays stable throughout DONE.

## Timing
- Reset values:
  - state = IDLE, `in_ready` = 1, `out_valid` = 0.
  - `out_result` = 0; counter and accumulators = 0.
- Accept in cycle 0; CALC runs in cycles 1..N; FIX is cycle N+1; `out_valid` first goes high in cycle N+2.
  - Full-width ops: `out_valid` in cycle 66.
  - W ops: `out_valid` in cycle 34.
  - Special cases: `out_valid` in cycle 1.
- The handshake completes on `out_valid & out_ready`. `in_ready` rises the following cycle, so there is no same-cycle accept and result.
- `out_ready` may be held high before DONE; it completes the handshake in the first DONE cycle.
- `flush` together with `out_valid & out_ready` counts as a flush: IDLE next cycle, and the upstream stage discards the result.
- `flush` in IDLE with `in_valid` high: the request is not accepted.
- Asynchronous reset mid-operation: immediate return to IDLE with all outputs at their reset values.

## Structure
- Put the following in `defines.v` alongside the existing ALU op macros: `MduOpWidth`, `MduMul`…`MduRemuw` encodings, the state encodings, and `XLEN`.
- One sub-module, `mdu_negate`: a combinational conditional two's-complement of a 2·XLEN value. It is reused in operand capture and in FIX.
- Counter: 6 bits. Control flags latched at accept: `is_div`, `is_w`, `neg_res`, `sel_hi`, `sel_rem`.

## Test plan
- MUL a=7, b=−3 → 0xFFFF_FFFF_FFFF_FFEB, with `out_valid` in cycle 66.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE; MULHSU a=−1, b=2 → 0xFFFF_FFFF_FFFF_FFFF.
- DIV a=−7, b=2 → −3; REM of the same operands → −1; DIVUW a=0x1_0000_0010, b=4 → 4, with `out_valid` in cycle 34.
- DIV a=5, b=0 → 0xFFFF…FFFF; REMW a=0x8000_0000, b=−1 → 0; DIVW of the same operands → 0xFFFF_FFFF_8000_0000. All three with `out_valid` in cycle 1.
- Assert `flush` in cycle 20 of a DIV → IDLE and `in_ready` = 1 in cycle 21, no `out_valid`; the next MULW a=0x8000_0000, b=2 → 0.
- Hold `out_ready` = 0 for 5 cycles in DONE → `out_result` stable and `in_ready` = 0; assert `rst` in CALC → outputs return to reset values immediately.

Source files
------------

// File: rtl/mdu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_seq_pkg
// Brief    : Shared widths, op encodings and state encodings for mdu_seq.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_seq_pkg;

  localparam int XLEN       = 64;
  localparam int MduOpWidth = 4;
  localparam int CntWidth   = 6;

  typedef enum logic [MduOpWidth-1:0] {
    MduMul    = 4'd0,
    MduMulh   = 4'd1,
    MduMulhsu = 4'd2,
    MduMulhu  = 4'd3,
    MduMulw   = 4'd4,
    MduDiv    = 4'd5,
    MduDivu   = 4'd6,
    MduRem    = 4'd7,
    MduRemu   = 4'd8,
    MduDivw   = 4'd9,
    MduDivuw  = 4'd10,
    MduRemw   = 4'd11,
    MduRemuw  = 4'd12
  } mduOp_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } mduState_e;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : mdu_seq_if
// Brief    : Request/result handshake bundle between execute and mdu_seq.
// Revision : 1.0 - initial release
// ============================================================================
interface mdu_seq_if;
  import mdu_seq_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [MduOpWidth-1:0] in_op;
  logic [XLEN-1:0]       in_a;
  logic [XLEN-1:0]       in_b;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       out_result;

  modport master (
    output in_valid, in_op, in_a, in_b, flush, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, flush, out_ready,
    output in_ready, out_valid, out_result
  );

endinterface
`default_nettype wire

// File: rtl/mdu_negate.sv
`default_nettype none
// ============================================================================
// Module   : mdu_negate
// Brief    : Combinational conditional two's-complement negate.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_negate
  import mdu_seq_pkg::*;
#(
  parameter int WIDTH = 2 * XLEN
) (
  input  logic [WIDTH-1:0] operand,
  input  logic             doNeg,
  output logic [WIDTH-1:0] negated
);

  assign negated = doNeg ? (~operand + WIDTH'(1)) : operand;

endmodule
`default_nettype wire

// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : mdu_seq
// Brief    : Multi-cycle RV64M multiply/divide sequencer (shift-add / restoring).
// Revision : 1.0 - initial release
// ============================================================================
module mdu_seq
  import mdu_seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  mdu_seq_if.slave     bus
);

  mduState_e             r_state, w_nextState;
  logic [CntWidth-1:0]   r_count;
  logic [2*XLEN-1:0]     r_acc;
  logic [XLEN:0]         r_rem;
  logic [XLEN-1:0]       r_op;
  logic [XLEN-1:0]       r_result;
  logic                  r_isDiv, r_isW, r_negRes, r_selHi, r_selRem;

  logic                  w_isW, w_isDiv, w_selHi, w_selRem, w_sgnA, w_sgnB;
  logic [XLEN-1:0]       w_extA, w_extB, w_magA, w_magB, w_minNeg, w_specialRes;
  logic                  w_negA, w_negB, w_divZero, w_ovf, w_special, w_accept, w_lastIter;
  logic [XLEN+1:0]       w_shift, w_trial;
  logic [XLEN:0]         w_sum;
  logic [2*XLEN-1:0]     w_fixIn, w_fixed;
  logic [XLEN-1:0]       w_fixRes;

  always_comb begin
    w_isW    = 1'b0;
    w_isDiv  = 1'b0;
    w_selHi  = 1'b0;
    w_selRem = 1'b0;
    w_sgnA   = 1'b0;
    w_sgnB   = 1'b0;
    case (bus.in_op)
      MduMulh:   begin w_selHi = 1'b1; w_sgnA = 1'b1; w_sgnB = 1'b1; end
      MduMulhsu: begin w_selHi = 1'b1; w_sgnA = 1'b1; end
      MduMulhu:  w_selHi = 1'b1;
      MduMulw:   begin w_isW = 1'b1; w_sgnA = 1'b1; w_sgnB = 1'b1; end
      MduDiv:    begin w_isDiv = 1'b1; w_sgnA = 1'b1; w_sgnB = 1'b1; end
      MduDivu:   w_isDiv = 1'b1;
      MduRem:    begin w_isDiv = 1'b1; w_selRem = 1'b1; w_sgnA = 1'b1; w_sgnB = 1'b1; end
      MduRemu:   begin w_isDiv = 1'b1; w_selRem = 1'b1; end
      MduDivw:   begin w_isDiv = 1'b1; w_isW = 1'b1; w_sgnA = 1'b1; w_sgnB = 1'b1; end
      MduDivuw:  begin w_isDiv = 1'b1; w_isW = 1'b1; end
      MduRemw:   begin w_isDiv = 1'b1; w_isW = 1'b1; w_selRem = 1'b1; w_sgnA = 1'b1; w_sgnB = 1'b1; end
      MduRemuw:  begin w_isDiv = 1'b1; w_isW = 1'b1; w_selRem = 1'b1; end
      default:   ;
    endcase
  end

  assign w_extA = w_isW ? (w_sgnA ? sext32(bus.in_a[31:0]) : {32'b0, bus.in_a[31:0]}) : bus.in_a;
  assign w_extB = w_isW ? (w_sgnB ? sext32(bus.in_b[31:0]) : {32'b0, bus.in_b[31:0]}) : bus.in_b;
  assign w_negA = w_sgnA & w_extA[XLEN-1];
  assign w_negB = w_sgnB & w_extB[XLEN-1];

  mdu_negate #(.WIDTH(XLEN)) u_negA (.operand(w_extA), .doNeg(w_negA), .negated(w_magA));
  mdu_negate #(.WIDTH(XLEN)) u_negB (.operand(w_extB), .doNeg(w_negB), .negated(w_magB));

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  assign w_minNeg  = w_isW ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
  assign w_divZero = w_isDiv & (w_extB == '0);
  assign w_ovf     = w_isDiv & w_sgnA & w_sgnB & (w_extA == w_minNeg) & (&w_extB);
  assign w_special = w_divZero | w_ovf;

  always_comb begin
    w_specialRes = '0;
    if (w_divZero)
      w_specialRes = w_selRem ? (w_isW ? sext32(bus.in_a[31:0]) : bus.in_a) : '1;
    else if (w_ovf)
      w_specialRes = w_selRem ? '0 : w_extA;
  end

  assign w_accept   = bus.in_valid & (r_state == StIdle) & ~bus.flush;
  assign w_lastIter = (r_count == (r_isW ? CntWidth'(31) : CntWidth'(63)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      StIdle:  if (w_accept) w_nextState = w_special ? StDone : StCalc;
      StCalc:  if (w_lastIter) w_nextState = StFix;
      StFix:   w_nextState = StDone;
      StDone:  if (bus.out_ready) w_nextState = StIdle;
      default: w_nextState = StIdle;
    endcase
    if (bus.flush) w_nextState = StIdle;
  end

  // Restoring step: the top bit of the 66-bit trial is the borrow.
  assign w_shift = {r_rem, r_acc[XLEN-1]};
  assign w_trial = w_shift - {2'b0, r_op};
  assign w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_op} : '0);

  // W multiplies run 32 steps, leaving the product 32 bits above its final place.
  assign w_fixIn = r_isDiv ? {{XLEN{1'b0}}, (r_selRem ? r_rem[XLEN-1:0] : r_acc[XLEN-1:0])}
                 : (r_isW ? {32'b0, r_acc[2*XLEN-1:32]} : r_acc);

  mdu_negate u_negRes (.operand(w_fixIn), .doNeg(r_negRes), .negated(w_fixed));

  assign w_fixRes = r_isW ? sext32(w_fixed[31:0])
                  : ((!r_isDiv && r_selHi) ? w_fixed[2*XLEN-1:XLEN] : w_fixed[XLEN-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_isDiv  <= 1'b0;
      r_isW    <= 1'b0;
      r_negRes <= 1'b0;
      r_selHi  <= 1'b0;
      r_selRem <= 1'b0;
    end else begin
      case (r_state)
        StIdle: if (w_accept) begin
          r_count  <= '0;
          r_rem    <= '0;
          r_isDiv  <= w_isDiv;
          r_isW    <= w_isW;
          r_selHi  <= w_selHi;
          r_selRem <= w_selRem;
          r_negRes <= w_selRem ? w_negA : (w_negA ^ w_negB);
          r_op     <= w_isDiv ? w_magB : w_magA;
          if (w_isDiv)
            r_acc <= {{XLEN{1'b0}}, (w_isW ? {w_magA[31:0], 32'b0} : w_magA)};
          else
            r_acc <= {{XLEN{1'b0}}, w_magB};
          if (w_special) r_result <= w_specialRes;
        end
        StCalc: begin
          r_count <= r_count + CntWidth'(1);
          if (r_isDiv) begin
            if (!w_trial[XLEN+1]) begin
              r_rem <= w_trial[XLEN:0];
              r_acc <= {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-2:0], 1'b1};
            end else begin
              r_rem <= w_shift[XLEN:0];
              r_acc <= {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-2:0], 1'b0};
            end
          end else begin
            r_acc <= {w_sum, r_acc[XLEN-1:1]};
          end
        end
        StFix:   r_result <= w_fixRes;
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = (r_state == StIdle);
  assign bus.out_valid  = (r_state == StDone);
  assign bus.out_result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_seq
// Brief    : Directed scoreboard bench for mdu_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_seq;
  import mdu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [XLEN-1:0] sb[$];

  mdu_seq_if bus();

  mdu_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Issues one op, waits for out_valid (bounded), checks latency and result.
  task automatic runOp(input string tag, input mduOp_e op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] res, input int lat);
    int cyc;
    logic [XLEN-1:0] expv;
    sb.push_back(res);
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(lat));
    expv = sb.pop_front();
    check({tag, " result"}, bus.out_result, expv);
    if (bus.out_ready) begin
      @(posedge clk); #1;
      check({tag, " in_ready after"}, 64'(bus.in_ready), 64'd1);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    logic sawValid;
    logic [XLEN-1:0] held;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset out_result", bus.out_result, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    runOp("MUL 7*-3", MduMul, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66);
    runOp("MULHU max", MduMulhu, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66);
    runOp("MULHSU -1*2", MduMulhsu, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    runOp("MULH -2*3", MduMulh, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    runOp("DIV -7/2", MduDiv, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    runOp("REM -7%2", MduRem, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    runOp("REMU 100%7", MduRemu, 64'd100, 64'd7, 64'd2, 66);
    runOp("DIVUW", MduDivuw, 64'h1_0000_0010, 64'd4, 64'd4, 34);
    runOp("DIVW -20/3", MduDivw, 64'hFFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 34);
    runOp("REMW -20%3", MduRemw, 64'hFFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 34);
    runOp("DIV by zero", MduDiv, 64'd5, 64'd0, '1, 1);
    runOp("REMW ovf", MduRemw, 64'h8000_0000, '1, 64'd0, 1);
    runOp("DIVW ovf", MduDivw, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1);
    runOp("REMUW by zero", MduRemuw, 64'h1_8000_0005, 64'h7_0000_0000, 64'hFFFF_FFFF_8000_0005, 1);

    // Flush in IDLE blocks acceptance.
    bus.in_op = MduDiv; bus.in_a = 64'd9; bus.in_b = 64'd0;
    bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    check("flush idle in_ready", 64'(bus.in_ready), 64'd1);
    check("flush idle out_valid", 64'(bus.out_valid), 64'd0);

    // Flush during cycle 20 of a DIV.
    bus.in_op = MduDiv; bus.in_a = 64'd100; bus.in_b = 64'd3;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cyc = 1;
    sawValid = 1'b0;
    while (cyc < 20) begin
      if (bus.out_valid) sawValid = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush calc in_ready", 64'(bus.in_ready), 64'd1);
    check("flush calc no valid", 64'(sawValid | bus.out_valid), 64'd0);
    runOp("MULW after flush", MduMulw, 64'h8000_0000, 64'd2, 64'd0, 34);

    // Result held stable while the consumer stalls.
    bus.out_ready = 1'b0;
    runOp("MUL hold", MduMul, 64'h1234, 64'h10, 64'h12340, 66);
    held = 64'h12340;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold result", bus.out_result, held);
      check("hold in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("release in_ready", 64'(bus.in_ready), 64'd1);
    check("release out_valid", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset in CALC.
    bus.in_op = MduDivu; bus.in_a = 64'd1000; bus.in_b = 64'd7;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("calc in_ready low", 64'(bus.in_ready), 64'd0);
    rst = 1'b1;
    #1;
    check("async rst in_ready", 64'(bus.in_ready), 64'd1);
    check("async rst out_valid", 64'(bus.out_valid), 64'd0);
    check("async rst out_result", bus.out_result, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    runOp("DIVU after rst", MduDivu, 64'd1000, 64'd7, 64'd142, 66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
